apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 38 +++
 rtl/apb_req_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter.
package apb_arb_pkg;

  // Width of the ACCESS-phase timeout counter (TIMEOUT is limited to 1..255).
  localparam int TO_W = 8;

  // Transfer sequencing: accept a request, run the two APB phases, report back.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: the first asserted request found when
// searching upward from last_grant+1, wrapping modulo N. Output is one-hot,
// or zero when nothing is requested.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant
);

  // Walk the N candidate positions in priority order and keep the first hit.
  always_comb begin
    int   pos;
    logic found;
    grant = '0;
    found = 1'b0;
    pos   = 0;
    for (int s = 1; s <= N; s++) begin
      pos = int'(last_grant) + s;
      if (pos >= N) begin
        pos = pos - N;
      end else begin
        pos = pos;
      end
      for (int k = 0; k < N; k++) begin
        if (!found && (k == pos) && req[k]) begin
          grant[k] = 1'b1;
          found    = 1'b1;
        end else begin
          grant[k] = grant[k];
        end
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Multi-requester front end for a single APB master port. Requesters are
// served one at a time in round-robin order; each accepted request runs a
// full SETUP/ACCESS sequence and is answered with a one-cycle rsp_valid.
// A slave that never raises pready is cut off after TIMEOUT ACCESS cycles.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 17,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [31:0]               pwdata,
  input  logic [31:0]               prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  grant_s;
  logic                hs_s;
  logic [IDX_W-1:0]    sel_idx_s;
  logic                sel_write_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [31:0]         sel_wdata_s;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant_s)
  );

  // Handshake detection and selection of the winning requester's payload.
  always_comb begin
    hs_s        = |(req_valid & req_ready);
    sel_idx_s   = '0;
    sel_write_s = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = 32'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_s[k]) begin
        sel_idx_s   = IDX_W'(k);
        sel_write_s = req_write[k];
        sel_addr_s  = req_addr[k*ADDR_W +: ADDR_W];
        sel_wdata_s = req_wdata[k*32 +: 32];
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
  end

  // State register; reset wins over any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the transfer sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready || (cnt_q == TO_LAST)) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs: grant in IDLE, APB phase strobes, response pulse.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst) begin
          req_ready = '0;
        end else begin
          req_ready = grant_s;
        end
      end
      ST_SETUP: begin
        psel = 1'b1;
      end
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      ST_RESP: begin
        for (int k = 0; k < NUM_REQ; k++) begin
          rsp_valid[k] = (idx_q == IDX_W'(k));
        end
      end
      default: begin
        psel = 1'b0;
      end
    endcase
  end

  // Datapath updates: latch the request, run the timeout, capture the result.
  always_comb begin
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          last_grant_d = sel_idx_s;
          idx_d        = sel_idx_s;
          pwrite_d     = sel_write_s;
          paddr_d      = sel_addr_s;
          pwdata_d     = sel_wdata_s;
        end else begin
          last_grant_d = last_grant_q;
        end
      end
      ST_SETUP: begin
        cnt_d = '0;
      end
      ST_ACCESS: begin
        if (pready) begin
          // Writes return no data, so the read bus is not sampled for them.
          rdata_d = pwrite_q ? 32'd0 : prdata;
          err_d   = pslverr;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath registers; last_grant resets so that requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= LAST_INIT;
      idx_q        <= '0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= 32'd0;
      cnt_q        <= '0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios followed by
// randomized transfers, compared against a transaction-level reference.
module tb_apb_req_arbiter;

  localparam int N  = 3;
  localparam int AW = 17;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [31:0]     rsp_rdata, pwdata, prdata;
  logic            rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0]   paddr;

  int n_checks = 0;
  int n_errors = 0;
  int last_g;

  apb_req_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first requester at or after last+1, wrapping.
  function automatic int rr_model(input logic [N-1:0] v, input int last);
    logic [N-1:0] t;
    for (int s = 1; s <= N; s++) begin
      t = v >> ((last + s) % N);
      if (t[0]) return (last + s) % N;
    end
    return -1;
  endfunction

  // Next clock: inputs change 1ns after the edge, checks happen 2ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // One complete transfer. waits = pready-low ACCESS cycles before pready;
  // rst_at >= 0 asserts reset during that ACCESS cycle instead.
  task automatic do_txn(input logic [N-1:0] v, input int waits, input bit rnd,
                        input logic dw, input logic [AW-1:0] da, input logic [31:0] dd,
                        input logic [31:0] drd, input logic dse, input int rst_at);
    int           w, k;
    bit           done, timed_out;
    logic [N-1:0] tw;
    logic         exp_wr, exp_err, fin_se;
    logic [AW-1:0] exp_a;
    logic [31:0]  exp_d, exp_rd, fin_rd;

    step();
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_write = {req_write[N-2:0], rnd ? 1'($urandom_range(0, 1)) : dw};
      req_addr  = {req_addr[(N-1)*AW-1:0], rnd ? AW'($urandom) : da};
      req_wdata = {req_wdata[(N-1)*32-1:0], rnd ? 32'($urandom) : dd};
    end
    pready  = 1'($urandom_range(0, 1));
    pslverr = 1'($urandom_range(0, 1));
    prdata  = $urandom;
    w = rr_model(v, last_g);
    tw = req_write >> w;
    exp_wr = tw[0];
    exp_a  = AW'(req_addr >> (w * AW));
    exp_d  = 32'(req_wdata >> (w * 32));
    settle();
    chk("idle_req_ready", req_ready, 64'(1) << w);
    chk("idle_psel", psel, 0);

    // SETUP
    step();
    pready = 1'($urandom_range(0, 1));
    prdata = $urandom;
    settle();
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, exp_a);
    chk("setup_pwrite", pwrite, exp_wr);
    chk("setup_pwdata", pwdata, exp_d);
    chk("setup_req_ready", req_ready, 0);

    fin_rd = rnd ? 32'($urandom) : drd;
    fin_se = rnd ? 1'($urandom_range(0, 1)) : dse;

    // ACCESS
    done = 1'b0;
    k = 0;
    while (!done) begin
      step();
      pready  = (k == waits);
      prdata  = (k == waits) ? fin_rd : 32'($urandom);
      pslverr = (k == waits) ? fin_se : 1'($urandom_range(0, 1));
      if (rst_at == k) rst = 1'b1;
      settle();
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_rsp_valid", rsp_valid, 0);
      if (rst_at == k) begin
        step();
        rst = 1'b0;
        req_valid = '0;
        pready = 1'b0;
        settle();
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        step();
        settle();
        chk("rst_after_rsp_valid", rsp_valid, 0);
        last_g = N - 1;
        return;
      end
      if ((k == waits) || (k == TO - 1)) done = 1'b1;
      k++;
    end

    timed_out = (waits >= TO);
    exp_rd  = (timed_out || exp_wr) ? 32'd0 : fin_rd;
    exp_err = timed_out ? 1'b1 : fin_se;

    // RESP (request still held: must not be re-granted here)
    step();
    pready  = 1'($urandom_range(0, 1));
    pslverr = 1'($urandom_range(0, 1));
    prdata  = $urandom;
    settle();
    chk("resp_rsp_valid", rsp_valid, 64'(1) << w);
    chk("resp_rdata", rsp_rdata, exp_rd);
    chk("resp_err", rsp_err, exp_err);
    chk("resp_psel", psel, 0);
    chk("resp_penable", penable, 0);
    chk("resp_paddr_hold", paddr, exp_a);
    chk("resp_req_ready", req_ready, 0);

    // Back in IDLE: pulse over, response data held.
    step();
    req_valid = '0;
    pready = 1'($urandom_range(0, 1));
    settle();
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_rdata_hold", rsp_rdata, exp_rd);
    chk("idle_err_hold", rsp_err, exp_err);
    chk("idle_psel_after", psel, 0);
    chk("idle_ready_none", req_ready, 0);
    last_g = w;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = 32'd0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    last_g    = N - 1;
    repeat (3) @(posedge clk);
    #1;
    settle();
    chk("reset_psel", psel, 0);
    chk("reset_penable", penable, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_paddr", paddr, 0);
    chk("reset_pwdata", pwdata, 0);
    chk("reset_pwrite", pwrite, 0);
    chk("reset_rdata", rsp_rdata, 0);
    chk("reset_err", rsp_err, 0);
    step();
    rst = 1'b0;

    // Single write, zero wait states: minimum latency.
    do_txn(3'b001, 0, 1'b0, 1'b1, 17'h00104, 32'hA5A5A5A5, 32'h0, 1'b0, -1);
    // Slave stuck not-ready: timeout after exactly TO ACCESS cycles.
    do_txn(3'b010, 10, 1'b1, 1'b0, '0, 32'h0, 32'h0, 1'b0, -1);
    // Read with two wait states ending in a slave error.
    do_txn(3'b100, 2, 1'b0, 1'b0, 17'h1F0A4, 32'h0, 32'h12345678, 1'b1, -1);
    // Reset in the middle of ACCESS, then round-robin restarts at requester 0.
    do_txn(3'b001, 5, 1'b1, 1'b0, '0, 32'h0, 32'h0, 1'b0, 1);
    for (int t = 0; t < 4; t++) begin
      do_txn(3'b011, $urandom_range(0, 2), 1'b0, 1'b0, AW'($urandom), $urandom,
             $urandom, 1'b0, -1);
    end
    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      do_txn(3'($urandom_range(1, 7)), $urandom_range(0, 5), 1'b1, 1'b0, '0,
             32'h0, 32'h0, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
